// File: rtl/cv32e40p_alu_ft_reconfig_ctrl.sv
// Reconfiguration controller for the fault-tolerant ALU: attributes voter errors to replicas,
// retires faulty replicas onto the ALU3 spare. Optional counter decay: CV32E40P_FT_ERR_DECAY_EN.
module cv32e40p_alu_ft_reconfig_ctrl #(
    parameter int unsigned ERR_THRESH   = 8,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned DECAY_PERIOD = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_enable_i,
    input  logic       ex_ready_i,
    input  logic       alu_ready_i,
    input  logic [2:0] err_detected_i,
    output logic [2:0] sel_mux_ex_o,
    output logic [3:0] clock_en_o,
    output logic [3:0] permanent_faulty_o,
    output logic [3:0] perf_trigger_o,
    output logic       err_uncorrectable_o,
    output logic       degraded_o,
    output logic       fatal_o
);

    typedef enum logic [1:0] {StNormal, StSwapPend, StDegraded, StFatal} state_t;

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntPreTh = CNT_W'(ERR_THRESH - 1);

    if (ERR_THRESH == 0 || ERR_THRESH > (2 ** CNT_W) - 1 || DECAY_PERIOD < 2) begin : gen_bad_cfg
        $error("invalid ERR_THRESH/CNT_W/DECAY_PERIOD");
    end

    state_t            state_q;
    logic [1:0]        victim_q;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [3:0]        inc_vec, dec_vec, fault_new;
    logic              valid, single, multi;
    logic [1:0]        slot, phys;

    assign valid  = alu_enable_i & ex_ready_i;
    assign single = valid & (err_detected_i == 3'b001 || err_detected_i == 3'b010 ||
                             err_detected_i == 3'b100);
    assign multi  = valid & ((err_detected_i[0] & err_detected_i[1]) |
                             (err_detected_i[0] & err_detected_i[2]) |
                             (err_detected_i[1] & err_detected_i[2]));
    assign slot   = err_detected_i[1] ? 2'd1 : (err_detected_i[2] ? 2'd2 : 2'd0);
    assign phys   = sel_mux_ex_o[slot] ? slot : 2'd3;

`ifdef CV32E40P_FT_ERR_DECAY_EN
    localparam int unsigned DecW = $clog2(DECAY_PERIOD);
    logic [DecW-1:0] decay_q;
    logic            decay_tick;

    assign decay_tick = (decay_q == DecW'(DECAY_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) decay_q <= '0;
        else        decay_q <= decay_tick ? '0 : decay_q + 1'b1;
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            dec_vec[r] = decay_tick & (cnt_q[r] != '0) & ~permanent_faulty_o[r];
        end
    end
`else
    assign dec_vec = 4'b0000;
`endif

    // Faulty replicas are frozen; a simultaneous increment and decay cancel out.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            inc_vec[r]   = single & (phys == 2'(r)) & ~permanent_faulty_o[r];
            cnt_d[r]     = cnt_q[r];
            fault_new[r] = 1'b0;
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] != CntMax) cnt_d[r] = cnt_q[r] + 1'b1;
                fault_new[r] = (cnt_q[r] == CntPreTh);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < 4; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= StNormal;
            victim_q            <= 2'd0;
            sel_mux_ex_o        <= 3'b111;
            clock_en_o          <= 4'b0111;
            permanent_faulty_o  <= 4'b0000;
            perf_trigger_o      <= 4'b0000;
            err_uncorrectable_o <= 1'b0;
            degraded_o          <= 1'b0;
            fatal_o             <= 1'b0;
        end else begin
            permanent_faulty_o  <= permanent_faulty_o | fault_new;
            perf_trigger_o      <= fault_new;
            err_uncorrectable_o <= multi;
            unique case (state_q)
                StNormal: begin
                    if (|fault_new[2:0]) begin
                        state_q  <= StSwapPend;
                        victim_q <= fault_new[1] ? 2'd1 : (fault_new[2] ? 2'd2 : 2'd0);
                    end
                end
                StSwapPend: begin
                    // A second fault before the swap leaves no spare for it.
                    if (|fault_new) begin
                        state_q <= StFatal;
                        fatal_o <= 1'b1;
                    end else if (alu_ready_i) begin
                        state_q                <= StDegraded;
                        sel_mux_ex_o[victim_q] <= 1'b0;
                        clock_en_o             <= 4'b1111 & ~(4'b0001 << victim_q);
                        degraded_o             <= 1'b1;
                    end
                end
                StDegraded: begin
                    if (|fault_new) begin
                        state_q <= StFatal;
                        fatal_o <= 1'b1;
                    end
                end
                StFatal: ;
                default: state_q <= StFatal;
            endcase
        end
    end

endmodule
